// File: rtl/issue_queue_age.sv
// -----------------------------------------------------------------------------
// issue_queue_age
//
// Out-of-order issue queue. Up to PW micro-ops are dispatched per cycle into
// the lowest-index free slots; one entry per cycle is issued over a
// valid/ready handshake. A whole-queue flush discards every entry.
//
// Build option:
//   ISSUE_AGE_ORDER_EN  defined   : an age matrix tracks relative age and the
//                                   oldest operands-ready entry is selected.
//                       undefined : no age matrix; the lowest-index
//                                   operands-ready entry is selected.
//
// Ports:
//   CLK                 clock
//   RST                 synchronous active-high reset
//   push_valid[PW]      per-lane dispatch request, contiguous from lane 0
//   push_info[DW*PW]    lane k payload in bits [DW*k +: DW]
//   push_ready          queue can absorb PW entries this cycle
//   entry_ready[DP]     per-slot operands-ready from the wakeup logic
//   issue_valid         a selected entry is presented
//   issue_ready         execute unit accepts the presented entry
//   issue_info[DW]      payload of the selected entry (0 when idle)
//   issue_index         slot of the selected entry (0 when idle)
//   flush               discard all entries at the next edge
//   buffer_malloc_qout  registered slot-valid bits
//   issue_info_qout     registered payload of all slots, slot i at [DW*i +: DW]
//   free_cnt            number of free slots
// -----------------------------------------------------------------------------
module issue_queue_age #(
  parameter int DW = 100,
  parameter int DP = 8,
  parameter int PW = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PW-1:0]         push_valid,
  input  logic [DW*PW-1:0]      push_info,
  output logic                  push_ready,
  input  logic [DP-1:0]         entry_ready,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [DW-1:0]         issue_info,
  output logic [$clog2(DP)-1:0] issue_index,
  input  logic                  flush,
  output logic [DP-1:0]         buffer_malloc_qout,
  output logic [DW*DP-1:0]      issue_info_qout,
  output logic [$clog2(DP):0]   free_cnt
);

  localparam int IW = $clog2(DP);
  localparam int CW = IW + 1;

  logic [DP-1:0] valid_q;
  logic [DW-1:0] payload_q [DP];

  logic [DP-1:0] slot_push;            // slot is written by an accepted lane
  logic [DW-1:0] slot_data [DP];
  logic [CW-1:0] free_rank;
  logic [DP-1:0] cand;
  logic [DP-1:0] sel_oh;
  logic [IW-1:0] sel_idx;
  logic [DP-1:0] issue_clr;

  // ---------------------------------------------------------------------------
  // Occupancy, from registered state only: a slot freed by an issue this cycle
  // is not counted as free until the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value, and every output is given a default first so no path
    // leaves it unassigned (which would infer a latch).
    free_cnt = CW'(DP);
    for (int s = 0; s < DP; s++) begin
      if (valid_q[s]) free_cnt = free_cnt - CW'(1);
    end
  end

  assign push_ready = (free_cnt >= CW'(PW));

  // ---------------------------------------------------------------------------
  // Slot allocation: lane k takes the k-th lowest free slot. free_rank counts
  // free slots seen so far while scanning upward.
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_push = '0;
    free_rank = '0;
    for (int s = 0; s < DP; s++) slot_data[s] = '0;
    for (int s = 0; s < DP; s++) begin
      if (!valid_q[s]) begin
        for (int k = 0; k < PW; k++) begin
          if (free_rank == CW'(k) && push_valid[k] && push_ready && !flush) begin
            slot_push[s] = 1'b1;
            slot_data[s] = push_info[DW*k +: DW];
          end
        end
        free_rank = free_rank + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------------
  assign cand = valid_q & entry_ready;

`ifdef ISSUE_AGE_ORDER_EN
  // age_q[i][j] = 1 : slot i is older than slot j.
  logic [DP-1:0][DP-1:0] age_q;
  logic [DP-1:0][DP-1:0] age_d;

  // A candidate wins when no other candidate is older than it. The age matrix
  // is a total order over valid slots, so exactly one bit survives.
  always_comb begin
    for (int i = 0; i < DP; i++) begin
      sel_oh[i] = cand[i];
      for (int j = 0; j < DP; j++) begin
        if (cand[j] && age_q[j][i]) sel_oh[i] = 1'b0;
      end
    end
  end

  // Lanes land in ascending slot order, so "the slot of a lower accepted lane"
  // is exactly "a slot pushed this cycle with a lower index". Row clears come
  // first so that same-cycle lower lanes can then be marked older.
  always_comb begin
    age_d = age_q;
    for (int s = 0; s < DP; s++) begin
      if (slot_push[s]) age_d[s] = '0;
    end
    for (int s = 0; s < DP; s++) begin
      if (slot_push[s]) begin
        for (int j = 0; j < DP; j++) begin
          if (valid_q[j] || (slot_push[j] && j < s)) age_d[j][s] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) age_q <= '0;
    else              age_q <= age_d;
  end
`else
  assign sel_oh = cand;
`endif

  // Lowest set bit of sel_oh; yields 0 when nothing is selected.
  always_comb begin
    sel_idx = '0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (sel_oh[i]) sel_idx = IW'(i);
    end
  end

  assign issue_valid = |cand;
  assign issue_index = sel_idx;
  assign issue_info  = issue_valid ? payload_q[sel_idx] : '0;
  assign issue_clr   = (issue_valid && issue_ready) ? (DP'(1) << sel_idx) : '0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (RST) begin
      valid_q <= '0;
      // NOTE: the payload array is reset because issue_info_qout exposes every
      // slot directly and must read 0 after reset; otherwise storage arrays
      // are normally left unreset.
      for (int s = 0; s < DP; s++) payload_q[s] <= '0;
    end else begin
      // Flush wins over both the handshake and pushes (slot_push is already
      // gated by flush, so payloads are untouched too).
      if (flush) valid_q <= '0;
      else       valid_q <= (valid_q & ~issue_clr) | slot_push;
      for (int s = 0; s < DP; s++) begin
        if (slot_push[s]) payload_q[s] <= slot_data[s];
      end
    end
  end

  assign buffer_malloc_qout = valid_q;

  always_comb begin
    issue_info_qout = '0;
    for (int s = 0; s < DP; s++) issue_info_qout[DW*s +: DW] = payload_q[s];
  end

endmodule

// File: tb/tb_issue_queue_age.sv
// -----------------------------------------------------------------------------
// tb_issue_queue_age
//
// Self-checking bench for issue_queue_age (DW=100, DP=8, PW=2). The reference
// model keeps per-slot valid/payload plus a dispatch sequence number; the
// oldest entry is simply the one with the smallest sequence number.
// -----------------------------------------------------------------------------
module tb_issue_queue_age;

  localparam int DW = 100;
  localparam int DP = 8;
  localparam int PW = 2;
  localparam int IW = 3;
  localparam int CW = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [PW-1:0]     push_valid;
  logic [DW*PW-1:0]  push_info;
  logic              push_ready;
  logic [DP-1:0]     entry_ready;
  logic              issue_valid;
  logic              issue_ready;
  logic [DW-1:0]     issue_info;
  logic [IW-1:0]     issue_index;
  logic              flush;
  logic [DP-1:0]     buffer_malloc_qout;
  logic [DW*DP-1:0]  issue_info_qout;
  logic [CW-1:0]     free_cnt;

  issue_queue_age #(.DW(DW), .DP(DP), .PW(PW)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .push_valid         (push_valid),
    .push_info          (push_info),
    .push_ready         (push_ready),
    .entry_ready        (entry_ready),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_info         (issue_info),
    .issue_index        (issue_index),
    .flush              (flush),
    .buffer_malloc_qout (buffer_malloc_qout),
    .issue_info_qout    (issue_info_qout),
    .free_cnt           (free_cnt)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_valid [DP];
  logic [DW-1:0] m_pay [DP];
  int unsigned m_seq   [DP];
  int unsigned seq_ctr = 0;

  // Model outputs
  int              exp_free;
  bit              exp_push_ready;
  bit              exp_iv;
  int              exp_idx;
  logic [DW-1:0]   exp_info;
  logic [DP-1:0]   exp_mask;
  logic [DW*DP-1:0] exp_qout;

  function automatic logic [DW-1:0] rand_pay();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic model_eval();
    int best;
    exp_free = 0;
    exp_mask = '0;
    exp_qout = '0;
    for (int s = 0; s < DP; s++) begin
      exp_mask[s] = m_valid[s];
      if (!m_valid[s]) exp_free++;
      exp_qout[DW*s +: DW] = m_pay[s];
    end
    exp_push_ready = (exp_free >= PW);
    best = -1;
    for (int s = 0; s < DP; s++) begin
      if (m_valid[s] && entry_ready[s]) begin
`ifdef ISSUE_AGE_ORDER_EN
        if (best < 0 || m_seq[s] < m_seq[best]) best = s;
`else
        if (best < 0) best = s;
`endif
      end
    end
    exp_iv   = (best >= 0);
    exp_idx  = (best >= 0) ? best : 0;
    exp_info = (best >= 0) ? m_pay[best] : '0;
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int free_list[$];
    int slot;
    model_eval();
    if (RST) begin
      for (int s = 0; s < DP; s++) begin
        m_valid[s] = 1'b0;
        m_pay[s]   = '0;
      end
    end else if (flush) begin
      for (int s = 0; s < DP; s++) m_valid[s] = 1'b0;
    end else begin
      for (int s = 0; s < DP; s++) if (!m_valid[s]) free_list.push_back(s);
      if (exp_iv && issue_ready) m_valid[exp_idx] = 1'b0;
      if (exp_push_ready) begin
        for (int k = 0; k < PW; k++) begin
          if (push_valid[k]) begin
            slot          = free_list[k];
            m_valid[slot] = 1'b1;
            m_pay[slot]   = push_info[DW*k +: DW];
            m_seq[slot]   = seq_ctr;
            seq_ctr++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic drive(input logic [PW-1:0] pv, input logic [DP-1:0] er,
                       input logic ir, input logic fl);
    push_valid = pv;
    for (int k = 0; k < PW; k++) push_info[DW*k +: DW] = rand_pay();
    entry_ready = er;
    issue_ready = ir;
    flush       = fl;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    drive('0, 8'hFF, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'h00) begin failures++; $display("FAIL reset_mask: got %h expected 00", buffer_malloc_qout); end
    checks++; if (free_cnt !== 4'd8) begin failures++; $display("FAIL reset_free_cnt: got %0d expected 8", free_cnt); end
    checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
    checks++; if (issue_info_qout !== '0) begin failures++; $display("FAIL reset_payloads: nonzero payload after reset"); end
  endtask

  task automatic test_fill();
    logic [DP-1:0] mask_tab [4];
    int            free_tab [4];
    mask_tab = '{8'h03, 8'h0F, 8'h3F, 8'hFF};
    free_tab = '{6, 4, 2, 0};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, '0, 1'b0, 1'b0);
      settle();
      checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL fill_push_ready[%0d]: got %b expected 1", c, push_ready); end
      tick();
      drive('0, '0, 1'b0, 1'b0);
      settle();
      checks++; if (buffer_malloc_qout !== mask_tab[c]) begin failures++; $display("FAIL fill_mask[%0d]: got %h expected %h", c, buffer_malloc_qout, mask_tab[c]); end
      checks++; if (free_cnt !== CW'(free_tab[c])) begin failures++; $display("FAIL fill_free_cnt[%0d]: got %0d expected %0d", c, free_cnt, free_tab[c]); end
    end
    // Push into a full queue is ignored.
    drive(2'b11, '0, 1'b0, 1'b0);
    settle();
    checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL full_push_ready: got %b expected 0", push_ready); end
    tick();
    drive('0, '0, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'hFF) begin failures++; $display("FAIL full_mask: got %h expected ff", buffer_malloc_qout); end
    checks++; if (issue_info_qout !== exp_qout) begin failures++; $display("FAIL full_payloads: got %h expected %h", issue_info_qout, exp_qout); end
    // Free one slot; with free_cnt=1 < PW pushes are still refused.
    drive('0, 8'h08, 1'b1, 1'b0);
    settle();
    checks++; if (issue_index !== 3'd3) begin failures++; $display("FAIL fill_issue_index: got %0d expected 3", issue_index); end
    tick();
    drive(2'b11, '0, 1'b0, 1'b0);
    settle();
    checks++; if (free_cnt !== 4'd1) begin failures++; $display("FAIL one_free_cnt: got %0d expected 1", free_cnt); end
    checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL one_free_push_ready: got %b expected 0", push_ready); end
    tick();
    drive('0, '0, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'hF7) begin failures++; $display("FAIL one_free_mask: got %h expected f7", buffer_malloc_qout); end
    checks++; if (issue_info_qout !== exp_qout) begin failures++; $display("FAIL one_free_payloads: got %h expected %h", issue_info_qout, exp_qout); end
  endtask

  task automatic test_age_order();
    int exp_order [3];
`ifdef ISSUE_AGE_ORDER_EN
    exp_order = '{1, 2, 0};
`else
    exp_order = '{0, 1, 2};
`endif
    do_reset();
    drive(2'b11, '0, 1'b0, 1'b0);   // A -> 0, B -> 1
    tick();
    drive(2'b01, '0, 1'b0, 1'b0);   // C -> 2
    tick();
    drive('0, 8'h01, 1'b1, 1'b0);   // issue A
    settle();
    checks++; if (issue_valid !== 1'b1 || issue_index !== 3'd0) begin failures++; $display("FAIL age_issue_a: got v=%b idx=%0d expected v=1 idx=0", issue_valid, issue_index); end
    checks++; if (issue_info !== exp_info) begin failures++; $display("FAIL age_issue_a_info: got %h expected %h", issue_info, exp_info); end
    tick();
    drive(2'b01, '0, 1'b0, 1'b0);   // D -> 0
    tick();
    for (int n = 0; n < 3; n++) begin
      drive('0, 8'hFF, 1'b1, 1'b0);
      settle();
      checks++; if (issue_valid !== 1'b1 || issue_index !== IW'(exp_order[n])) begin failures++; $display("FAIL age_order[%0d]: got v=%b idx=%0d expected v=1 idx=%0d", n, issue_valid, issue_index, exp_order[n]); end
      checks++; if (issue_info !== exp_info) begin failures++; $display("FAIL age_order_info[%0d]: got %h expected %h", n, issue_info, exp_info); end
      tick();
    end
    drive('0, 8'hFF, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'h00 || issue_valid !== 1'b0) begin failures++; $display("FAIL age_drained: got mask=%h v=%b expected 00/0", buffer_malloc_qout, issue_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, '0, 1'b0, 1'b0);
      tick();
    end
    drive(2'b11, 8'h08, 1'b1, 1'b0);
    settle();
    checks++; if (free_cnt !== 4'd2 || push_ready !== 1'b1) begin failures++; $display("FAIL b2b_pre: got free=%0d rdy=%b expected 2/1", free_cnt, push_ready); end
    checks++; if (issue_index !== 3'd3) begin failures++; $display("FAIL b2b_issue_index: got %0d expected 3", issue_index); end
    tick();
    drive('0, '0, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'hF7) begin failures++; $display("FAIL b2b_mask: got %h expected f7", buffer_malloc_qout); end
    checks++; if (free_cnt !== 4'd1) begin failures++; $display("FAIL b2b_free_cnt: got %0d expected 1", free_cnt); end
    checks++; if (issue_info_qout !== exp_qout) begin failures++; $display("FAIL b2b_payloads: got %h expected %h", issue_info_qout, exp_qout); end
  endtask

  task automatic test_flush();
    // Queue holds 7 entries from the previous scenario.
    drive(2'b11, 8'hFF, 1'b1, 1'b1);
    settle();
    checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL flush_issue_valid: got %b expected 1", issue_valid); end
    tick();
    drive('0, 8'hFF, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'h00) begin failures++; $display("FAIL flush_mask: got %h expected 00", buffer_malloc_qout); end
    checks++; if (free_cnt !== 4'd8) begin failures++; $display("FAIL flush_free_cnt: got %0d expected 8", free_cnt); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_after_valid: got %b expected 0", issue_valid); end
    drive(2'b01, '0, 1'b0, 1'b0);
    tick();
    drive('0, 8'hFF, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'h01 || issue_index !== 3'd0) begin failures++; $display("FAIL flush_repush: got mask=%h idx=%0d expected 01/0", buffer_malloc_qout, issue_index); end
    checks++; if (issue_info !== exp_info) begin failures++; $display("FAIL flush_repush_info: got %h expected %h", issue_info, exp_info); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(2'b11, '0, 1'b0, 1'b0); tick();
    drive(2'b11, '0, 1'b0, 1'b0); tick();
    drive(2'b01, '0, 1'b0, 1'b0); tick();
    drive('0, '0, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'h1F) begin failures++; $display("FAIL mid_pre_mask: got %h expected 1f", buffer_malloc_qout); end
    RST = 1'b1;
    drive(2'b11, 8'hFF, 1'b1, 1'b0);
    tick();
    RST = 1'b0;
    drive('0, 8'hFF, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'h00 || free_cnt !== 4'd8) begin failures++; $display("FAIL mid_reset_state: got mask=%h free=%0d expected 00/8", buffer_malloc_qout, free_cnt); end
    checks++; if (push_ready !== 1'b1 || issue_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_flags: got rdy=%b v=%b expected 1/0", push_ready, issue_valid); end
    checks++; if (issue_info_qout !== '0) begin failures++; $display("FAIL mid_reset_payloads: nonzero payload after reset"); end
    drive(2'b01, '0, 1'b0, 1'b0);
    tick();
    drive('0, '0, 1'b0, 1'b0);
    settle();
    checks++; if (buffer_malloc_qout !== 8'h01) begin failures++; $display("FAIL mid_reset_first_push: got %h expected 01", buffer_malloc_qout); end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      n = $urandom_range(0, PW);
      drive(PW'((1 << n) - 1), DP'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0));
      settle();
      checks++;
      if (buffer_malloc_qout !== exp_mask || free_cnt !== CW'(exp_free) ||
          push_ready !== exp_push_ready || issue_valid !== exp_iv ||
          issue_index !== IW'(exp_idx) || issue_info !== exp_info ||
          issue_info_qout !== exp_qout) begin
        failures++;
        $display("FAIL random[%0d]: got mask=%h free=%0d rdy=%b v=%b idx=%0d info=%h expected mask=%h free=%0d rdy=%b v=%b idx=%0d info=%h",
                 c, buffer_malloc_qout, free_cnt, push_ready, issue_valid, issue_index, issue_info,
                 exp_mask, exp_free, exp_push_ready, exp_iv, exp_idx, exp_info);
      end
      tick();
    end
  endtask

  initial begin
    RST         = 1'b1;
    push_valid  = '0;
    push_info   = '0;
    entry_ready = '0;
    issue_ready = 1'b0;
    flush       = 1'b0;
    for (int s = 0; s < DP; s++) begin
      m_valid[s] = 1'b0;
      m_pay[s]   = '0;
      m_seq[s]   = 0;
    end
    test_reset();
    test_fill();
    test_age_order();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
